// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator: forms the format-selected immediate and pc+imm,
// and hands them downstream through a valid/ready stage backed by a 2-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [2:0]       in_imm_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_imm_sel
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0, SEL_I = 3'd1, SEL_U = 3'd2, SEL_S = 3'd3,
    SEL_J    = 3'd4, SEL_B = 3'd5, SEL_Z = 3'd6, SEL_SH = 3'd7
  } imm_sel_e;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      sel;
  } entry_t;

  state_e          r_state;
  entry_t          r_main;
  entry_t          r_skid;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_pc_x;
  entry_t          w_new;
  logic            w_accept;
  logic            w_retire;

  // Every format is first built as a 32-bit two's-complement value; zero-extended
  // formats have a clear top bit, so one sign extension to XLEN covers them all.
  always_comb begin
    w_imm32 = '0;
    case (imm_sel_e'(in_imm_sel))
      SEL_I:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      SEL_U:  w_imm32 = {in_instr[31:12], 12'b0};
      SEL_S:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SEL_J:  w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      SEL_B:  w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_Z:  w_imm32 = {27'b0, in_instr[19:15]};
      SEL_SH: w_imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  if (PC_W >= XLEN) begin : g_pc_trunc
    assign w_pc_x = in_pc[XLEN-1:0];
  end else begin : g_pc_zext
    assign w_pc_x = {{(XLEN-PC_W){1'b0}}, in_pc};
  end

  assign w_new.imm    = w_imm;
  assign w_new.target = w_pc_x + w_imm;
  assign w_new.pc     = in_pc;
  assign w_new.instr  = in_instr;
  assign w_new.sel    = in_imm_sel;

  // Both handshake flags decode only the state register, so in_ready has no path from out_ready.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;

  // NOTE: non-blocking assignments throughout, so the FULL->ONE move reads the old skid
  // content; the data registers are reset too, because outputs must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main  <= w_new;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_retire) begin
            r_main <= w_new;
          end else if (w_accept) begin
            r_skid  <= w_new;
            r_state <= FULL;
          end else if (w_retire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_retire) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_imm     = r_main.imm;
  assign out_target  = r_main.target;
  assign out_pc      = r_main.pc;
  assign out_instr   = r_main.instr;
  assign out_imm_sel = r_main.sel;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed format cases, back-pressure, flush, async reset, and a
// randomized run against a queue-based reference model; a second instance covers XLEN=32.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [63:0] in_pc, out_pc, out_imm, out_target;
  logic [2:0]  in_imm_sel, out_imm_sel;

  logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_instr32, out_instr32, in_pc32, out_pc32, out_imm32, out_target32;
  logic [2:0]  in_imm_sel32, out_imm_sel32;

  imm_gen_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_imm_sel(in_imm_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
    .out_instr(out_instr), .out_imm_sel(out_imm_sel));

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_instr(in_instr32), .in_pc(in_pc32), .in_imm_sel(in_imm_sel32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_imm(out_imm32), .out_target(out_target32), .out_pc(out_pc32),
    .out_instr(out_instr32), .out_imm_sel(out_imm_sel32));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] target;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [2:0]  sel;
  } exp_t;

  exp_t        q[$];
  logic [31:0] retired[$];

  // Reference immediate: gather the field as an unsigned number, then apply two's-complement
  // interpretation of its width arithmetically, then reduce modulo 2^xl.
  function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] sel, int xl);
    longint unsigned f;
    longint unsigned b31, b20, b7;
    int w;
    bit sgn;
    f = 0; w = 32; sgn = 0;
    b31 = longint'((ins >> 31) & 1);
    b20 = longint'((ins >> 20) & 1);
    b7  = longint'((ins >> 7) & 1);
    case (sel)
      3'd1: begin f = longint'(ins >> 20); w = 12; sgn = 1; end
      3'd2: begin f = longint'(ins & 32'hFFFF_F000); w = 32; sgn = 1; end
      3'd3: begin f = longint'(((ins >> 25) << 5) | ((ins >> 7) & 31)); w = 12; sgn = 1; end
      3'd4: begin
        f = (b31 << 20) + (longint'((ins >> 12) & 255) << 12) + (b20 << 11)
            + (longint'((ins >> 21) & 1023) << 1);
        w = 21; sgn = 1;
      end
      3'd5: begin
        f = (b31 << 12) + (b7 << 11) + (longint'((ins >> 25) & 63) << 5)
            + (longint'((ins >> 8) & 15) << 1);
        w = 13; sgn = 1;
      end
      3'd6: f = longint'((ins >> 15) & 31);
      3'd7: f = (xl == 64) ? longint'((ins >> 20) & 63) : longint'((ins >> 20) & 31);
      default: f = 0;
    endcase
    if (sgn && f >= (64'd1 << (w - 1))) f = f - (64'd1 << w);
    if (xl == 32) f = f & 64'hFFFF_FFFF;
    return f;
  endfunction

  function automatic exp_t make_exp(logic [31:0] ins, logic [63:0] pc, logic [2:0] sel, int xl);
    exp_t e;
    logic [63:0] pcx;
    pcx      = (xl == 32) ? (pc & 64'hFFFF_FFFF) : pc;
    e.imm    = ref_imm(ins, sel, xl);
    e.target = pcx + e.imm;
    if (xl == 32) e.target = e.target & 64'hFFFF_FFFF;
    e.pc     = pc;
    e.instr  = ins;
    e.sel    = sel;
    return e;
  endfunction

  // One clock of stimulus on the 64-bit instance, entered and left at a falling edge;
  // the model queue holds exactly the entries that should be inside the stage.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic [2:0] sel, input logic rdy, input logic fl);
    bit acc, ret;
    in_valid = v; in_instr = ins; in_pc = pc; in_imm_sel = sel; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2);
    ret = rdy && (q.size() > 0);
    if (out_valid && rdy) retired.push_back(out_instr);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(make_exp(ins, pc, sel, 64));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_flags: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    n_cmp++;
    if ({out_imm, out_target, out_pc, out_instr, out_imm_sel} !== '0) begin
      n_err++; $display("FAIL reset_data: got imm %h tgt %h pc %h instr %h sel %h expected all 0",
                        out_imm, out_target, out_pc, out_instr, out_imm_sel);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, out_imm, out_instr} !== {2'b01, 96'd0}) begin
      n_err++; $display("FAIL reset_held: got valid %b ready %b imm %h instr %h expected 0 1 0 0",
                        out_valid, in_ready, out_imm, out_instr);
    end
  endtask

  task automatic test_formats();
    logic [31:0] ins [9] = '{32'hFFF00093, 32'h800000B7, 32'hFE112C23, 32'hFE000EE3, 32'hFFDFF06F,
                             32'h000F8073, 32'h03F00093, 32'hFFFFFFFF, 32'h7FF00093};
    logic [2:0]  sel [9] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [63:0] pc  [9] = '{64'h8000_0000, 64'h0, 64'h1000, 64'h8000_0010, 64'h8000_0010,
                             64'h0, 64'h100, 64'h44, 64'hFFFF_FFFF_FFFF_FF00};
    logic [63:0] imm [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFF8,
                             64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1F, 64'h3F, 64'h0,
                             64'h7FF};
    logic [63:0] tgt [9] = '{64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'hFF8, 64'h8000_000C,
                             64'h8000_000C, 64'h1F, 64'h13F, 64'h44, 64'h6FF};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, ins[i], pc[i], sel[i], 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== ins[i] || out_imm_sel !== sel[i] || out_pc !== pc[i]) begin
        n_err++; $display("FAIL fmt%0d_carry: got valid %b instr %h sel %0d pc %h expected 1 %h %0d %h",
                          i, out_valid, out_instr, out_imm_sel, out_pc, ins[i], sel[i], pc[i]);
      end
      n_cmp++;
      if (out_imm !== imm[i]) begin
        n_err++; $display("FAIL fmt%0d_imm: got %h expected %h", i, out_imm, imm[i]);
      end
      n_cmp++;
      if (out_target !== tgt[i]) begin
        n_err++; $display("FAIL fmt%0d_target: got %h expected %h", i, out_target, tgt[i]);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a = 32'h0010_0093, b = 32'h0020_0093, c = 32'h0030_0093;
    logic [31:0] want [3];
    want = '{a, b, c};
    retired.delete();
    drive(1'b1, a, 64'h10, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_after_a: got ready %b valid %b expected 1 1", in_ready, out_valid);
    end
    drive(1'b1, b, 64'h14, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || out_instr !== a) begin
      n_err++; $display("FAIL bp_after_b: got ready %b instr %h expected 0 %h", in_ready, out_instr, a);
    end
    drive(1'b1, c, 64'h18, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || out_instr !== a || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_stall: got ready %b valid %b instr %h expected 0 1 %h",
                        in_ready, out_valid, out_instr, a);
    end
    drive(1'b1, c, 64'h18, 3'd1, 1'b1, 1'b0);
    drive(1'b1, c, 64'h18, 3'd1, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (retired.size() != 3) begin
      n_err++; $display("FAIL bp_count: got %0d retirements expected 3", retired.size());
    end
    for (int i = 0; i < 3 && i < retired.size(); i++) begin
      n_cmp++;
      if (retired[i] !== want[i]) begin
        n_err++; $display("FAIL bp_order%0d: got %h expected %h", i, retired[i], want[i]);
      end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0040_0093, 64'h20, 3'd1, 1'b0, 1'b0);
    drive(1'b1, 32'h0050_0093, 64'h24, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_full: got ready %b expected 0", in_ready);
    end
    drive(1'b1, 32'h0060_0093, 64'h28, 3'd1, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_empty: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
    retired.delete();
    repeat (3) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (retired.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_ghost: got %0d retirements valid %b expected 0 0",
                        retired.size(), out_valid);
    end
    drive(1'b1, 32'h0070_0093, 64'h2C, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0070_0093 || out_imm !== 64'h7) begin
      n_err++; $display("FAIL flush_recover: got valid %b instr %h imm %h expected 1 00700093 7",
                        out_valid, out_instr, out_imm);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'hFFF0_0093, 64'h8000_0000, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got valid %b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_imm, out_target, out_pc, out_instr, out_imm_sel} !== {2'b01, 227'd0}) begin
      n_err++; $display("FAIL arst_now: got valid %b ready %b imm %h tgt %h pc %h instr %h sel %h expected 0 1 0",
                        out_valid, in_ready, out_imm, out_target, out_pc, out_instr, out_imm_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    drive(1'b1, 32'hFE00_0EE3, 64'h8000_0010, 3'd5, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFE00_0EE3 || out_target !== 64'h8000_000C) begin
      n_err++; $display("FAIL arst_first: got valid %b instr %h tgt %h expected 1 fe000ee3 8000000c",
                        out_valid, out_instr, out_target);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [63:0] pc;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      pc  = {$urandom, $urandom};
      drive($urandom_range(0, 9) < 7, ins, pc, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      n_cmp++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        n_err++; $display("FAIL rnd%0d_flags: got valid %b ready %b expected occupancy %0d",
                          i, out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (out_imm !== q[0].imm || out_target !== q[0].target || out_pc !== q[0].pc ||
            out_instr !== q[0].instr || out_imm_sel !== q[0].sel) begin
          n_err++; $display("FAIL rnd%0d_data: got imm %h tgt %h pc %h instr %h sel %0d expected %h %h %h %h %0d",
                            i, out_imm, out_target, out_pc, out_instr, out_imm_sel,
                            q[0].imm, q[0].target, q[0].pc, q[0].instr, q[0].sel);
        end
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_xlen32();
    exp_t e;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [2:0]  sel;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: begin ins = 32'h8000_00B7; pc = 32'h0;         sel = 3'd2; end
        1: begin ins = 32'h03F0_0093; pc = 32'h0;         sel = 3'd7; end
        2: begin ins = 32'h0200_0093; pc = 32'hFFFF_FFF0; sel = 3'd1; end
        default: begin ins = $urandom; pc = $urandom; sel = 3'($urandom_range(0, 7)); end
      endcase
      e = make_exp(ins, {32'd0, pc}, sel, 32);
      in_valid32 = 1'b1; in_instr32 = ins; in_pc32 = pc; in_imm_sel32 = sel;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid32 !== 1'b1 || out_imm32 !== e.imm[31:0] || out_target32 !== e.target[31:0] ||
          out_instr32 !== ins) begin
        n_err++; $display("FAIL x32_%0d: got valid %b imm %h tgt %h instr %h expected 1 %h %h %h",
                          i, out_valid32, out_imm32, out_target32, out_instr32,
                          e.imm[31:0], e.target[31:0], ins);
      end
      if (i == 0) begin
        n_cmp++;
        if (out_imm32 !== 32'h8000_0000) begin
          n_err++; $display("FAIL x32_lui: got %h expected 80000000", out_imm32);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (out_imm32 !== 32'h1F) begin
          n_err++; $display("FAIL x32_shamt: got %h expected 0000001f", out_imm32);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (out_target32 !== 32'h10) begin
          n_err++; $display("FAIL x32_wrap: got %h expected 00000010", out_target32);
        end
      end
    end
    in_valid32 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_imm_sel = '0;
    flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1;
    in_instr32 = '0; in_pc32 = '0; in_imm_sel32 = '0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_formats();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    test_xlen32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered successor to the combinational sign-extension unit. Extracts the immediate for the selected RISC-V format, extends it to XLEN, and computes pc+imm. Results are presented through a valid/ready pipeline stage with a 2-entry skid buffer. It sits between decode and execute in the NPC, so the immediate path is registered and back-pressure stalls decode cleanly.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
PC_W, XLEN, width of the PC field carried through the stage.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous kill of all buffered entries.
in_valid  input  1  upstream entry valid.
in_ready  output  1  stage can accept an entry this cycle.
in_instr  input  32  raw instruction word.
in_pc  input  PC_W  PC of in_instr.
in_imm_sel  input  3  format: 0 NONE, 1 I, 2 U, 3 S, 4 J, 5 B, 6 Z (CSR zimm), 7 SH (shamt).
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
out_pc  output  PC_W  carried PC.
out_instr  output  32  carried instruction.
out_imm_sel  output  3  carried selector.

Behaviour:
- Reset is asynchronous and active-low:
  - rst_n=0 clears main_valid, skid_valid and every data register to 0.
  - While rst_n=0: out_valid=0, out_imm=0, out_target=0, out_pc=0, out_instr=0, out_imm_sel=0, in_ready=1.
- Immediate formation (combinational on the input side, registered at accept):
  - I: sext(instr[31:20]).
  - U: sext({instr[31:12],12'b0}). For XLEN=32 the value is used as-is.
  - S: sext({instr[31:25],instr[11:7]}).
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Z: zext(instr[19:15]).
  - SH: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
  - NONE: 0.
- sext replicates the top bit of the field to XLEN. Target = in_pc (zero-extended or truncated to XLEN) + imm, computed before registering.
- Latency: an entry accepted in cycle N appears at the output in cycle N+1 when the output register is free.
- Handshake:
  - Accept when in_valid && in_ready. Retire when out_valid && out_ready.
  - in_ready = !skid_valid, driven straight from the register with no combinational path from out_ready.
  - Output signals are stable while out_valid && !out_ready.
- Storage: main register (drives the outputs) plus skid register.
  - States: EMPTY (main_valid=0), ONE (main only), FULL (main+skid).
  - EMPTY + accept -> ONE.
  - ONE + accept + retire -> ONE (main reloads with the new entry).
  - ONE + accept, no retire -> FULL (new entry goes to skid).
  - ONE + retire, no accept -> EMPTY.
  - FULL + retire -> ONE (skid moves to main). No accept is possible in FULL because in_ready=0.
- Ordering: strictly FIFO; skid content always retires before any later entry.
- flush: the next state is EMPTY regardless of accept or retire in the same cycle. An entry offered in the flush cycle is dropped; in_ready may still read 1 in that cycle. Flush beats accept.
- Reset mid-operation: all in-flight entries are lost and no partial output is ever presented.
- Illegal XLEN (not 32 or 64) fails elaboration.

Test Plan:
- XLEN=64, I, instr 0xFFF00093 (addi x1,x0,-1), pc 0x80000000 -> one cycle later out_imm=0xFFFFFFFFFFFFFFFF, out_target=0x7FFFFFFF.
- XLEN=64, U, 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000. XLEN=32, same instr -> 0x80000000.
- S 0xFE112C23 (sw x1,-8(x2)) -> 0xFFFF_FFFF_FFFF_FFF8. B 0xFE000EE3 (beq -4), pc 0x80000010 -> imm -4, target 0x8000000C. J 0xFFDFF06F -> imm -4. Z with rs1 field 31 -> 0x1F.
- Back-pressure: out_ready=0, push entries A,B,C back-to-back -> A,B accepted, in_ready=0 from the cycle after B. Raise out_ready -> A,B,C retire in order, no duplicates or drops.
- flush asserted in FULL state together with a new in_valid -> next cycle out_valid=0, in_ready=1, the flushed entries never appear.
- rst_n pulled low asynchronously (mid-cycle) with out_valid=1 -> all outputs 0 immediately. After release, the first accepted entry appears exactly one cycle later.
